// File: rtl/instr_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [XLEN-1:0] IRQ_VEC_DEF  = 32'h8000_0004;
    localparam logic [XLEN-1:0] EXC_VEC_DEF  = 32'h8000_0008;
    localparam logic [XLEN-1:0] NOP          = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_REDIR,
        SEL_IRQ,
        SEL_EXC
    } next_pc_sel_e;

    // Sequential step: kernel/user bit is sticky, low 31 bits wrap.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1], 31'(pc[XLEN-2:0] + 31'd4)};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, pipeline control inputs and IF/ID outputs.
interface instr_fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] rom_addr;
    logic [XLEN-1:0] rom_data;
    logic            stall;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            irq;
    logic            exc;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_plus4;
    logic            if_valid;
    logic            trap_taken;
    logic [XLEN-1:0] epc;

    modport master (
        output rom_addr, if_instr, if_pc, if_pc_plus4, if_valid, trap_taken, epc,
        input  rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc
    );

    modport slave (
        input  rom_addr, if_instr, if_pc, if_pc_plus4, if_valid, trap_taken, epc,
        output rom_data, stall, flush, redirect_valid, redirect_pc, irq, exc
    );
endinterface

// File: rtl/instr_fetch_next_pc.sv
// Next-PC priority select: exc > irq > redirect > stall > sequential.
// Interrupt path present only when INSTR_FETCH_IRQ_EN is defined.
module instr_fetch_next_pc
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [XLEN-1:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [XLEN-1:0] pc,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            irq,
    input  logic            exc,
    output next_pc_sel_e    sel_c,
    output logic [XLEN-1:0] next_pc_c
);

    logic irq_take;

`ifdef INSTR_FETCH_IRQ_EN
    // Level request is only honoured in user mode on a non-stalled cycle.
    assign irq_take = irq && !pc[XLEN-1] && !stall;
`else
    logic unused_irq;
    assign unused_irq = irq;
    assign irq_take   = 1'b0;
`endif

    always_comb begin
        sel_c = SEL_SEQ;
        if (exc)                 sel_c = SEL_EXC;
        else if (irq_take)       sel_c = SEL_IRQ;
        else if (redirect_valid) sel_c = SEL_REDIR;
        else if (stall)          sel_c = SEL_HOLD;
    end

    always_comb begin
        next_pc_c = pc_inc(pc);
        unique case (sel_c)
            SEL_EXC:   next_pc_c = EXC_VEC;
`ifdef INSTR_FETCH_IRQ_EN
            SEL_IRQ:   next_pc_c = IRQ_VEC;
`endif
            SEL_REDIR: next_pc_c = {redirect_pc[XLEN-1:2], 2'b00};
            SEL_HOLD:  next_pc_c = pc;
            default:   next_pc_c = pc_inc(pc);
        endcase
    end

`ifndef INSTR_FETCH_IRQ_EN
    logic [XLEN-1:0] unused_irq_vec;
    assign unused_irq_vec = IRQ_VEC;
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC register, IF/ID register and trap entry.
// Optional interrupt support via INSTR_FETCH_IRQ_EN.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] IRQ_VEC  = IRQ_VEC_DEF,
    parameter logic [XLEN-1:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    next_pc_sel_e    sel;
    logic            trap;
    logic            bubble;

    instr_fetch_next_pc #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_next_pc (
        .pc             (pc),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .irq            (bus.irq),
        .exc            (bus.exc),
        .sel_c          (sel),
        .next_pc_c      (next_pc)
    );

    assign trap         = (sel == SEL_EXC) || (sel == SEL_IRQ);
    // A stalled redirect cannot keep the held instruction, so it bubbles too.
    assign bubble       = trap || bus.flush || (bus.redirect_valid && bus.stall);
    assign bus.rom_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.if_instr    <= NOP;
            bus.if_pc       <= '0;
            bus.if_pc_plus4 <= '0;
            bus.if_valid    <= 1'b0;
        end else if (bubble) begin
            bus.if_instr    <= NOP;
            bus.if_pc       <= pc;
            bus.if_pc_plus4 <= pc_inc(pc);
            bus.if_valid    <= 1'b0;
        end else if (!bus.stall) begin
            bus.if_instr    <= bus.rom_data;
            bus.if_pc       <= pc;
            bus.if_pc_plus4 <= pc_inc(pc);
            bus.if_valid    <= 1'b1;
        end
    end

    // Resume point is the redirect target if one lands with the trap.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.trap_taken <= 1'b0;
            bus.epc        <= '0;
        end else begin
            bus.trap_taken <= trap;
            if (trap) begin
                bus.epc <= bus.redirect_valid ? bus.redirect_pc : pc;
            end
        end
    end

endmodule
